// File: rtl/imem_responder.sv
// imem_responder: memory-side end of the instruction fetch interface.
// Word-organised program store with a load port, a wait-state counter before
// each response, and range/alignment fault detection.
// Optional macro IMEM_STATS_EN adds saturating fetch/fault counters.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [31:0]                    imem_addr,
  input  logic                           imem_req,
  output logic [31:0]                    imem_data,
  output logic                           imem_ready,
  output logic                           imem_fault,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data,
`ifdef IMEM_STATS_EN
  output logic [31:0]                    fetch_count,
  output logic [31:0]                    fault_count,
`endif
  output logic                           busy
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES);
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  logic [31:0] r_mem [DEPTH_WORDS];

  state_e      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [31:0] r_addr, w_addr_next;
  logic [31:0] r_data;
  logic        r_ready, r_fault, r_busy;

  logic [31:0] w_fetch_addr, w_offset;
  logic [29:0] w_index;
  logic        w_fault, w_enter_resp;

  // In IDLE the response may be taken straight from the live address (no wait states);
  // otherwise the latched address is the one being served.
  assign w_fetch_addr = (r_state == StIdle) ? imem_addr : r_addr;
  // Wrapping subtraction makes addresses below the base land far out of range.
  assign w_offset     = w_fetch_addr - BASE_ADDR;
  assign w_index      = w_offset[31:2];
  assign w_fault      = (w_offset[1:0] != 2'b00) || (w_index >= 30'(DEPTH_WORDS));

  // Next-state logic: load has priority and parks the FSM in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_addr_next  = r_addr;
    if (load_en) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (imem_req) begin
            w_addr_next  = imem_addr;
            w_cnt_next   = WaitLoad;
            w_state_next = (WAIT_STATES == 0) ? StResp : StWait;
          end
        end
        StWait: begin
          if (!imem_req) begin
            w_state_next = StIdle;
          end else if (imem_addr != r_addr) begin
            // Requester moved on: restart the wait for the new address.
            w_addr_next = imem_addr;
            w_cnt_next  = WaitLoad;
          end else if (r_cnt == 4'd1) begin
            w_cnt_next   = 4'd0;
            w_state_next = StResp;
          end else begin
            w_cnt_next = r_cnt - 4'd1;
          end
        end
        StResp:  w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  assign w_enter_resp = (w_state_next == StResp);

  // State and registered outputs; data/fault are captured on the edge into RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_addr  <= 32'h0;
      r_data  <= 32'h0;
      r_ready <= 1'b0;
      r_fault <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_addr  <= w_addr_next;
      r_ready <= w_enter_resp;
      r_fault <= w_enter_resp && w_fault;
      r_busy  <= (w_state_next != StIdle);
      if (w_enter_resp) begin
        r_data <= w_fault ? NopInstr : r_mem[w_index[AW-1:0]];
      end
    end
  end

  // Program-load write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      r_mem[load_addr] <= load_data;
    end
  end

  assign imem_data  = r_data;
  assign imem_ready = r_ready;
  assign imem_fault = r_fault;
  assign busy       = r_busy;

`ifdef IMEM_STATS_EN
  logic [31:0] r_fetch_cnt, r_fault_cnt;

  // Saturating counters of response and fault strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= 32'h0;
      r_fault_cnt <= 32'h0;
    end else begin
      if (r_ready && (r_fetch_cnt != 32'hFFFF_FFFF)) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (r_fault && (r_fault_cnt != 32'hFFFF_FFFF)) r_fault_cnt <= r_fault_cnt + 32'd1;
    end
  end

  assign fetch_count = r_fetch_cnt;
  assign fault_count = r_fault_cnt;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances with 0, 1 and 3 wait states sharing
// clock, reset and load port; responses checked against an address-level model.
module tb_imem_responder;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic                    clk;
  logic                    rst_n;
  logic [2:0][31:0]        addr;
  logic [2:0]              req;
  logic [2:0][31:0]        dat;
  logic [2:0]              rdy;
  logic [2:0]              flt;
  logic [2:0]              bsy;
  logic                    load_en;
  logic [$clog2(DEPTH)-1:0] load_addr;
  logic [31:0]             load_data;
`ifdef IMEM_STATS_EN
  logic [2:0][31:0]        fcnt;
  logic [2:0][31:0]        qcnt;
`endif

  int          checks = 0;
  int          errors = 0;
  int          ws_of[3] = '{0, 1, 3};
  logic [31:0] model_mem[DEPTH];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    imem_responder #(
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR  (BASE),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_addr  (addr[g]),
      .imem_req   (req[g]),
      .imem_data  (dat[g]),
      .imem_ready (rdy[g]),
      .imem_fault (flt[g]),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data),
`ifdef IMEM_STATS_EN
      .fetch_count(fcnt[g]),
      .fault_count(qcnt[g]),
`endif
      .busy       (bsy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: an address is served iff word-aligned and inside [BASE, BASE+4*DEPTH).
  function automatic logic exp_fault(input logic [31:0] a);
    longint unsigned av, lo, hi;
    av = {32'h0, a};
    lo = {32'h0, BASE};
    hi = lo + 4 * DEPTH;
    return (a[1:0] != 2'b00) || (av < lo) || (av >= hi);
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    logic [31:0] idx;
    if (exp_fault(a)) return NOP;
    idx = (a - BASE) / 4;
    return model_mem[idx[7:0]];
  endfunction

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel <= 5) return BASE + 4 * $urandom_range(0, DEPTH - 1);
    if (sel == 6) return BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
    if (sel == 7) return $urandom_range(0, BASE - 1);
    if (sel == 8) return BASE + 4 * DEPTH + 4 * $urandom_range(0, 1000);
    return $urandom;
  endfunction

  task automatic load_word(input int idx, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = idx[7:0];
    load_data = d;
    tick();
    load_en   = 1'b0;
    model_mem[idx] = d;
  endtask

  // Isolated fetch: request, wait for the strobe, check timing/data/fault, release.
  task automatic fetch_once(input int k, input logic [31:0] a, input string tag);
    int          n;
    logic [31:0] ed;
    logic        ef;
    ed = exp_data(a);
    ef = exp_fault(a);
    req[k]  = 1'b1;
    addr[k] = a;
    n = 0;
    do begin
      tick();
      n++;
      if (!rdy[k]) begin
        checks++;
        if (bsy[k] !== 1'b1) begin
          errors++;
          $display("FAIL %s busy inst=%0d cycle=%0d: got %b, want 1", tag, k, n, bsy[k]);
        end
      end
    end while (!rdy[k] && n < 40);
    checks++;
    if (!rdy[k]) begin
      errors++;
      $display("FAIL %s timeout inst=%0d addr=%h: no ready in %0d cycles", tag, k, a, n);
    end else begin
      checks++;
      if (n != ws_of[k] + 1) begin
        errors++;
        $display("FAIL %s latency inst=%0d addr=%h: got %0d, want %0d", tag, k, a, n,
                 ws_of[k] + 1);
      end
      checks++;
      if (dat[k] !== ed) begin
        errors++;
        $display("FAIL %s data inst=%0d addr=%h: got %h, want %h", tag, k, a, dat[k], ed);
      end
      checks++;
      if (flt[k] !== ef) begin
        errors++;
        $display("FAIL %s fault inst=%0d addr=%h: got %b, want %b", tag, k, a, flt[k], ef);
      end
    end
    req[k] = 1'b0;
    tick();
    checks++;
    if (rdy[k] !== 1'b0 || bsy[k] !== 1'b0 || flt[k] !== 1'b0) begin
      errors++;
      $display("FAIL %s release inst=%0d: ready=%b busy=%b fault=%b, want 0 0 0", tag, k,
               rdy[k], bsy[k], flt[k]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      checks += 4;
      if (rdy[k] !== 1'b0) begin errors++; $display("FAIL reset ready inst=%0d: got %b, want 0", k, rdy[k]); end
      if (flt[k] !== 1'b0) begin errors++; $display("FAIL reset fault inst=%0d: got %b, want 0", k, flt[k]); end
      if (bsy[k] !== 1'b0) begin errors++; $display("FAIL reset busy inst=%0d: got %b, want 0", k, bsy[k]); end
      if (dat[k] !== 32'h0) begin errors++; $display("FAIL reset data inst=%0d: got %h, want 0", k, dat[k]); end
`ifdef IMEM_STATS_EN
      checks++;
      if (fcnt[k] !== 32'h0 || qcnt[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset stats inst=%0d: got %0d/%0d, want 0/0", k, fcnt[k], qcnt[k]);
      end
`endif
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_program();
    load_word(0, 32'h0000_0093);
    load_word(1, 32'h0010_0113);
    for (int i = 2; i < int'(DEPTH); i++) load_word(i, $urandom);
  endtask

  task automatic test_basic();
    fetch_once(1, 32'h0000_0100, "basic0");
    fetch_once(1, 32'h0000_0104, "basic1");
  endtask

  // Zero wait states, request held: strobe on every other cycle, address advanced on each.
  task automatic test_back_to_back();
    logic [31:0] a;
    a = BASE + 4 * $urandom_range(0, DEPTH - 1);
    req[0]  = 1'b1;
    addr[0] = a;
    for (int t = 1; t <= 12; t++) begin
      tick();
      checks++;
      if (rdy[0] !== 1'(t % 2)) begin
        errors++;
        $display("FAIL b2b ready t=%0d: got %b, want %b", t, rdy[0], 1'(t % 2));
      end
      if (rdy[0] === 1'b1) begin
        checks++;
        if (dat[0] !== exp_data(a) || flt[0] !== 1'b0) begin
          errors++;
          $display("FAIL b2b data addr=%h: got %h/%b, want %h/0", a, dat[0], flt[0],
                   exp_data(a));
        end
        a = BASE + 4 * $urandom_range(0, DEPTH - 1);
        addr[0] = a;
      end
    end
    req[0] = 1'b0;
    tick();
    checks++;
    if (rdy[0] !== 1'b0) begin errors++; $display("FAIL b2b end ready: got %b, want 0", rdy[0]); end
  endtask

  task automatic test_faults();
    logic [31:0] list[4];
    list[0] = 32'h0000_0102;
    list[1] = 32'h0000_00FC;
    list[2] = BASE + 4 * DEPTH;
    list[3] = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) fetch_once(k, list[i], "fault");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) fetch_once(int'($urandom_range(0, 2)), rand_addr(), "rand");
  endtask

  task automatic test_abort_restart();
    int n;
    // Drop request in the second wait cycle: no response.
    req[2] = 1'b1; addr[2] = 32'h0000_0100;
    tick(); tick();
    req[2] = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      checks++;
      if (rdy[2] !== 1'b0 || bsy[2] !== 1'b0) begin
        errors++;
        $display("FAIL abort t=%0d: ready=%b busy=%b, want 0 0", t, rdy[2], bsy[2]);
      end
    end
    // Address change mid-wait restarts the full wait for the new address.
    req[2] = 1'b1; addr[2] = 32'h0000_0100;
    tick(); tick();
    addr[2] = 32'h0000_0200;
    n = 0;
    do begin tick(); n++; end while (!rdy[2] && n < 40);
    checks++;
    if (n != 4 || rdy[2] !== 1'b1) begin
      errors++;
      $display("FAIL restart latency: got %0d (ready=%b), want 4", n, rdy[2]);
    end
    checks++;
    if (dat[2] !== exp_data(32'h0000_0200) || flt[2] !== 1'b0) begin
      errors++;
      $display("FAIL restart data: got %h/%b, want %h/0", dat[2], flt[2],
               exp_data(32'h0000_0200));
    end
    req[2] = 1'b0;
    tick();
  endtask

  task automatic test_load_priority();
    int n;
    req[2] = 1'b1; addr[2] = 32'h0000_0100;
    tick();
    load_en = 1'b1; load_addr = '0; load_data = 32'hDEAD_BEEF;
    for (int t = 0; t < 2; t++) begin
      tick();
      checks++;
      if (rdy[2] !== 1'b0 || bsy[2] !== 1'b0) begin
        errors++;
        $display("FAIL loadprio held t=%0d: ready=%b busy=%b, want 0 0", t, rdy[2], bsy[2]);
      end
    end
    load_en = 1'b0;
    model_mem[0] = 32'hDEAD_BEEF;
    n = 0;
    do begin tick(); n++; end while (!rdy[2] && n < 40);
    checks++;
    if (n != 4 || rdy[2] !== 1'b1) begin
      errors++;
      $display("FAIL loadprio reissue latency: got %0d (ready=%b), want 4", n, rdy[2]);
    end
    checks++;
    if (dat[2] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL loadprio data: got %h, want deadbeef", dat[2]);
    end
    req[2] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    req[2] = 1'b1; addr[2] = 32'h0000_0100;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rdy[2] !== 1'b0 || flt[2] !== 1'b0 || bsy[2] !== 1'b0 || dat[2] !== 32'h0) begin
      errors++;
      $display("FAIL async reset: ready=%b fault=%b busy=%b data=%h, want all 0", rdy[2],
               flt[2], bsy[2], dat[2]);
    end
    req[2] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
`ifdef IMEM_STATS_EN
    checks++;
    if (fcnt[2] !== 32'h0) begin errors++; $display("FAIL stats after reset: got %0d, want 0", fcnt[2]); end
`endif
    fetch_once(2, 32'h0000_0100, "retained");
`ifdef IMEM_STATS_EN
    checks++;
    if (fcnt[2] !== 32'd1 || qcnt[2] !== 32'd0) begin
      errors++;
      $display("FAIL stats one fetch: got %0d/%0d, want 1/0", fcnt[2], qcnt[2]);
    end
    fetch_once(0, 32'h0000_0102, "statsfault");
    checks++;
    if (fcnt[0] !== 32'd1 || qcnt[0] !== 32'd1) begin
      errors++;
      $display("FAIL stats fault fetch: got %0d/%0d, want 1/1", fcnt[0], qcnt[0]);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0; req = '0; addr = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    test_reset();
    test_load_program();
    test_basic();
    test_back_to_back();
    test_faults();
    test_random();
    test_abort_restart();
    test_load_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
